bounce_gen: RTL
===============

# bounce_gen

Synthesizable contact-bounce emulator: the driving end of the button/debounce path. On command it moves a button-level output to a new level through a pseudo-random bounce burst followed by a clean settle interval. Its output drives the debouncer's `btn` input in on-board self-test and in benches, so debounce behaviour can be exercised with repeatable noisy presses and releases.

## Interface

Parameters:
- `BOUNCE_CYCLES`, default 8: length of the bounce burst in cycles; legal range 1..255.
- `SETTLE_CYCLES`, default 16: length of the clean-level interval after the burst; legal range 1..255.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: request to move `btn` to `cmd_level`.
- `cmd_level` in 1: target clean level (1 = pressed).
- `cmd_ready` out 1: high when a command can be accepted.
- `btn` out 1: emulated noisy button signal.
- `busy` out 1: high while a transition is in progress.
- `done` out 1: one-cycle pulse when a transition completes.

## Operation

- FSM states: IDLE, BOUNCE, SETTLE.
- Reset values: state IDLE; `btn`=0; `busy`=0; `done`=0; `cmd_ready`=1; LFSR=`LFSR_SEED`; counters 0; stored level 0.
- `cmd_ready` = (state == IDLE). A command is accepted on `cmd_valid && cmd_ready`. `cmd_level` is latched at acceptance.
- Same-level command (`cmd_level` equals the current `btn`): no burst. The FSM stays in IDLE, and `done` pulses in the next cycle.
- Different-level command: IDLE → BOUNCE, and the counter is loaded with the burst length.
- BOUNCE:
  - In the first cycle, `btn` = target level (first contact).
  - In the remaining cycles, `btn` = `lfsr[0]`.
  - The LFSR advances once per BOUNCE cycle only.
  - After the last burst cycle, the FSM goes to SETTLE.
- SETTLE: `btn` = target level for `SETTLE_CYCLES` cycles, then the FSM goes to IDLE with `done`=1 for one cycle.
- IDLE: `btn` holds the last target level.
- `busy` = state is BOUNCE or SETTLE.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Update: shift right; if the old bit0 was 1, XOR 16'hB400.
  - The LFSR is never reseeded except by `rst`.
- Counters are 8-bit down-counters. The terminal count is 1, so no wrap occurs.
- `cmd_valid` while `cmd_ready`=0 is ignored. No queuing is performed.

## Timing

- Command accepted at edge k, default parameters, level change:
  - `btn` = target level in cycle k+1.
  - Bounce cycles are k+1..k+8.
  - Settle cycles are k+9..k+24.
  - `done`=1 and `cmd_ready`=1 in cycle k+25.
- A new command may be accepted in the same cycle that `done` is high.
- `busy` is high in cycles k+1..k+24 and low in k+25.
- Same-level command accepted at edge k: `done`=1 in cycle k+1; `busy` stays 0.
- `rst` asserted in any state: at the next edge, all registers return to their reset values. `btn` drops to 0 even mid-burst. No `done` is issued for the aborted transition.
- `rst` has priority over a simultaneous `cmd_valid`.
- All outputs are registered. There are no combinational paths from `cmd_*` to `btn` or `done`. `cmd_ready` is decoded from the state register.

## Configuration

- Macro: `BOUNCE_GEN_RANDLEN_EN`.
- Defined: burst length = `BOUNCE_CYCLES` + `lfsr[3:0]`, using the LFSR value sampled at the accept edge, giving a range of `BOUNCE_CYCLES`..`BOUNCE_CYCLES`+15. The counter widens to 9 bits.
- Undefined: burst length is fixed at `BOUNCE_CYCLES`.
- All other behaviour is identical in both builds.

## Test plan

- Reset: hold `rst` 2 cycles → `btn`=0, `busy`=0, `done`=0, `cmd_ready`=1. The first accepted command's first random bounce bit equals bit0 of the LFSR state following 16'hACE1.
- Press, default build: `cmd_valid`=1, `cmd_level`=1 accepted at edge k →
  - `btn`=1 at k+1;
  - `btn` matches the reference LFSR model during k+2..k+8;
  - `btn`=1 during k+9..k+24;
  - `done` pulses only at k+25;
  - `btn` holds 1 afterwards.
- Same-level command: with `btn`=1, send `cmd_level`=1 → `done` at k+1, `busy` never high, `btn` constant 1.
- Back-to-back: issue a release (`cmd_level`=0) in the `done` cycle of a press → accepted immediately; `btn`=0 in the next cycle; second `done` 25 cycles later.
- Ignored command and reset mid-op:
  - `cmd_valid` pulsed during BOUNCE → no effect on timing.
  - `rst` asserted in cycle k+5 → `btn`=0 and `cmd_ready`=1 next cycle, no `done`; the next burst replays the seed sequence.
- `BOUNCE_GEN_RANDLEN_EN` defined: accept with sampled `lfsr[3:0]`=4'hA → burst of 18 cycles, `done` at k+35; undefined build → `done` at k+25.

Source files
------------

// File: rtl/bounce_gen.sv
// Contact-bounce emulator: moves btn to a commanded level through an LFSR-driven
// bounce burst and a clean settle interval. Define BOUNCE_GEN_RANDLEN_EN for random burst lengths.
module bounce_gen #(
  parameter int          BOUNCE_CYCLES = 8,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_level,
  output logic cmd_ready,
  output logic btn,
  output logic busy,
  output logic done
);

`ifdef BOUNCE_GEN_RANDLEN_EN
  localparam int CntW = 9;
`else
  localparam int CntW = 8;
`endif

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    SETTLE
  } state_t;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              level_q, level_d;
  logic              btn_q, btn_d;
  logic              done_q, done_d;
  logic [15:0]       lfsr_step;
  logic [CntW-1:0]   burst_len;

  // Galois form of x^16+x^14+x^13+x^11+1
  assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

`ifdef BOUNCE_GEN_RANDLEN_EN
  assign burst_len = CntW'(BOUNCE_CYCLES) + CntW'(lfsr_q[3:0]);
`else
  assign burst_len = CntW'(BOUNCE_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      level_q <= 1'b0;
      btn_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      level_q <= level_d;
      btn_q   <= btn_d;
      done_q  <= done_d;
    end
  end

  // btn_d is computed one cycle ahead, so the first-contact level is loaded at accept
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    level_d = level_q;
    btn_d   = btn_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          level_d = cmd_level;
          if (cmd_level == btn_q) begin
            done_d = 1'b1;
          end else begin
            state_d = BOUNCE;
            cnt_d   = burst_len;
            btn_d   = cmd_level;
          end
        end
      end
      BOUNCE: begin
        lfsr_d = lfsr_step;
        if (cnt_q == CntW'(1)) begin
          state_d = SETTLE;
          cnt_d   = CntW'(SETTLE_CYCLES);
          btn_d   = level_q;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          btn_d = lfsr_step[0];
        end
      end
      SETTLE: begin
        btn_d = level_q;
        if (cnt_q == CntW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == BOUNCE) || (state_q == SETTLE);
  assign btn       = btn_q;
  assign done      = done_q;

endmodule
